rotary_paddle_decoder: RTL

ROTARY_PADDLE_DECODER -- requirements
Module: rotary_paddle_decoder

---
 rtl/rotary_paddle_decoder.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/rotary_paddle_decoder.sv
// rtl/rotary_paddle_decoder.sv - debounced quadrature decoder driving a frame-stable paddle row
module rotary_paddle_decoder #(
  parameter int DEBOUNCE_CYCLES = 25000,
  parameter int PADDLE_MIN      = 0,
  parameter int PADDLE_MAX      = 416,
  parameter int PADDLE_STEP     = 8,
  parameter int PADDLE_INIT     = 208
) (
  input  logic       clk25,
  input  logic       reset,
  input  logic       rota,
  input  logic       rotb,
  input  logic       vsync,
  output logic [9:0] paddle_y,
  output logic       step_cw,
  output logic       step_ccw,
  output logic       moved
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [10:0] P_MIN  = 11'(PADDLE_MIN);
  localparam logic [10:0] P_MAX  = 11'(PADDLE_MAX);
  localparam logic [10:0] P_STEP = 11'(PADDLE_STEP);

  typedef enum logic [2:0] {IDLE, CW1, CW2, CW3, CCW1, CCW2, CCW3} state_t;

  // Bit 1 carries channel A, bit 0 channel B, so filt reads as {A,B}.
  logic [1:0]       sync1, sync2, filt, filt_q;
  logic [CNT_W-1:0] cnt [2];
  state_t           state, state_nxt;
  logic             cw_d, ccw_d;
  logic [9:0]       pos;
  logic [10:0]      pos_up, pos_dn;
  logic             vs_q;

  // Two-flop synchronizer for both raw encoder channels.
  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) begin
      sync1 <= 2'b00;
      sync2 <= 2'b00;
    end else begin
      sync1 <= {rota, rotb};
      sync2 <= sync1;
    end
  end

  // Per-channel debounce: a new level must persist DEBOUNCE_CYCLES cycles.
  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) begin
      filt <= 2'b00;
      for (int i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_LAST) begin
          filt[i] <= ~filt[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Decoder state register; step pulses are registered from the transition.
  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      filt_q   <= 2'b00;
      step_cw  <= 1'b0;
      step_ccw <= 1'b0;
    end else begin
      state    <= state_nxt;
      filt_q   <= filt;
      step_cw  <= cw_d;
      step_ccw <= ccw_d;
    end
  end

  // Next-state: forward, backward, or abandon on a two-bit jump.
  always_comb begin
    state_nxt = state;
    cw_d      = 1'b0;
    ccw_d     = 1'b0;
    if (filt != filt_q) begin
      if (filt == ~filt_q) begin
        state_nxt = IDLE;
      end else begin
        case (state)
          IDLE: if (filt_q == 2'b00) begin
                  if (filt == 2'b10)      state_nxt = CW1;
                  else if (filt == 2'b01) state_nxt = CCW1;
                end
          CW1:  if (filt == 2'b11) state_nxt = CW2;  else if (filt == 2'b00) state_nxt = IDLE;
          CW2:  if (filt == 2'b01) state_nxt = CW3;  else if (filt == 2'b10) state_nxt = CW1;
          CW3:  if (filt == 2'b00) begin
                  state_nxt = IDLE;
                  cw_d      = 1'b1;
                end else if (filt == 2'b11) state_nxt = CW2;
          CCW1: if (filt == 2'b11) state_nxt = CCW2; else if (filt == 2'b00) state_nxt = IDLE;
          CCW2: if (filt == 2'b10) state_nxt = CCW3; else if (filt == 2'b01) state_nxt = CCW1;
          CCW3: if (filt == 2'b00) begin
                  state_nxt = IDLE;
                  ccw_d     = 1'b1;
                end else if (filt == 2'b11) state_nxt = CCW2;
          default: state_nxt = IDLE;
        endcase
      end
    end
  end

  // Saturated candidate positions, computed one bit wider than the row.
  always_comb begin
    pos_up = {1'b0, pos} + P_STEP;
    if (pos_up > P_MAX) pos_up = P_MAX;
    if ({1'b0, pos} < P_MIN + P_STEP) pos_dn = P_MIN;
    else                              pos_dn = {1'b0, pos} - P_STEP;
  end

  // Internal position follows the registered step pulses.
  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) begin
      pos <= 10'(PADDLE_INIT);
    end else if (step_cw) begin
      pos <= pos_up[9:0];
    end else if (step_ccw) begin
      pos <= pos_dn[9:0];
    end
  end

  // Publish the position only at the start of vertical blanking.
  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) begin
      vs_q     <= 1'b1;
      paddle_y <= 10'(PADDLE_INIT);
      moved    <= 1'b0;
    end else begin
      vs_q  <= vsync;
      moved <= 1'b0;
      if (vs_q && !vsync) begin
        paddle_y <= pos;
        moved    <= (pos != paddle_y);
      end
    end
  end

endmodule
